// File: rtl/requant_stream_out_pkg.sv
// Shared constants and FSM state type for the requantizing AXIS output stage.
package requant_stream_out_pkg;

  localparam int unsigned ELEM0_SRAM_IDX = 0;
  localparam int unsigned MAX_DATA_WIDTH = 16;
  localparam int unsigned Q31_FRAC_BITS  = 31;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_RUN,
    RQ_DRAIN,
    RQ_DONE
  } rq_state_e;

endpackage

// File: rtl/requant_stream_out_core.sv
// 3-stage requantization pipeline: SRAM capture + multiply, rounding shift, zero-point + clamp.
module requant_stream_out_core
  import requant_stream_out_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic                        last_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic signed [31:0]          mult_i,
  input  logic [4:0]                  shift_i,
  input  logic signed [OUT_WIDTH-1:0] zp_i,
  input  logic signed [OUT_WIDTH-1:0] min_i,
  input  logic signed [OUT_WIDTH-1:0] max_i,
  output logic                        valid_o,
  output logic                        last_o,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic [1:0]                  inflight_o
);

  localparam int PROD_W = ACC_WIDTH + 32;
  localparam int RES_W  = 34;

  logic                     va_q, la_q;
  logic                     vb_q, lb_q;
  logic                     vc_q, lc_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [RES_W-1:0]  r_q;

  logic signed [PROD_W-1:0] acc_ext, mult_ext, prod_d;
  logic [6:0]               rnd_pos;
  logic signed [63:0]       prod_ext, rnd, sum, shifted;
  logic signed [RES_W-1:0]  zsum, min_ext, max_ext;

  assign acc_ext  = {{(PROD_W-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
  assign mult_ext = {{(PROD_W-32){mult_i[31]}}, mult_i};
  assign prod_d   = acc_ext * mult_ext;

  // Half-LSB bias before the arithmetic shift rounds ties toward +inf.
  assign rnd_pos  = 7'(Q31_FRAC_BITS - 1) + {2'b00, shift_i};
  assign prod_ext = {{(64-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign rnd      = 64'sd1 <<< rnd_pos;
  assign sum      = prod_ext + rnd;
  assign shifted  = sum >>> (rnd_pos + 7'd1);

  assign zsum    = r_q + {{(RES_W-OUT_WIDTH){zp_i[OUT_WIDTH-1]}}, zp_i};
  assign min_ext = {{(RES_W-OUT_WIDTH){min_i[OUT_WIDTH-1]}}, min_i};
  assign max_ext = {{(RES_W-OUT_WIDTH){max_i[OUT_WIDTH-1]}}, max_i};

  always_comb begin
    data_o = zsum[OUT_WIDTH-1:0];
    if (zsum < min_ext)      data_o = min_i;
    else if (zsum > max_ext) data_o = max_i;
  end

  assign valid_o    = vc_q;
  assign last_o     = lc_q;
  assign inflight_o = {1'b0, va_q} + {1'b0, vb_q} + {1'b0, vc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q   <= 1'b0;
      la_q   <= 1'b0;
      vb_q   <= 1'b0;
      lb_q   <= 1'b0;
      vc_q   <= 1'b0;
      lc_q   <= 1'b0;
      prod_q <= '0;
      r_q    <= '0;
    end else begin
      va_q   <= valid_i;
      la_q   <= valid_i & last_i;
      vb_q   <= va_q;
      lb_q   <= la_q;
      prod_q <= prod_d;
      vc_q   <= vb_q;
      lc_q   <= lb_q;
      r_q    <= shifted[RES_W-1:0];
    end
  end

endmodule

// File: rtl/requant_stream_out.sv
// Reads accumulators from ELEM SRAM with credit-gated reads, requantizes to int8,
// and streams one AXIS frame through a small output FIFO.
module requant_stream_out
  import requant_stream_out_pkg::*;
#(
  parameter int ADDR_WIDTH         = 13,
  parameter int ACC_WIDTH          = 16,
  parameter int OUT_WIDTH          = 8,
  parameter int NUM_CHANNELS_WIDTH = 7,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         out_size,
  input  logic signed [31:0]            quant_mult,
  input  logic [4:0]                    quant_shift,
  input  logic signed [OUT_WIDTH-1:0]   out_zero_point,
  input  logic signed [OUT_WIDTH-1:0]   act_min,
  input  logic signed [OUT_WIDTH-1:0]   act_max,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          sram_rd_en,
  output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
  input  logic signed [ACC_WIDTH-1:0]   sram_rd_data,
  output logic signed [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [NUM_CHANNELS_WIDTH-1:0] m_axis_tuser,
  output logic                          busy,
  output logic                          done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;

  rq_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]         len_q, addr_q;
  logic signed [31:0]            mult_q;
  logic [4:0]                    shift_q;
  logic signed [OUT_WIDTH-1:0]   zp_q, min_q, max_q;
  logic [NUM_CHANNELS_WIDTH-1:0] user_q;

  logic [OUT_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;

  logic                        start_acc, rd_en, rd_last, credit_ok;
  logic                        push, pop, head_last;
  logic                        core_valid, core_last;
  logic signed [OUT_WIDTH-1:0] core_data;
  logic [1:0]                  core_inflight;
  logic [UW-1:0]               used;

  requant_stream_out_core #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (rd_en),
    .last_i     (rd_last),
    .acc_i      (sram_rd_data),
    .mult_i     (mult_q),
    .shift_i    (shift_q),
    .zp_i       (zp_q),
    .min_i      (min_q),
    .max_i      (max_q),
    .valid_o    (core_valid),
    .last_o     (core_last),
    .data_o     (core_data),
    .inflight_o (core_inflight)
  );

  // Elements already issued but not yet in the FIFO still hold a slot, so the FIFO cannot overflow.
  assign used      = {1'b0, cnt_q} + UW'(core_inflight);
  assign credit_ok = used < UW'(FIFO_DEPTH);
  assign rd_last   = (addr_q == len_q - ADDR_WIDTH'(1));

  assign push      = core_valid;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign head_last = mem_q[rd_ptr_q][OUT_WIDTH];

  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & head_last;
  assign m_axis_tuser  = user_q;
  assign sram_rd_en    = rd_en;
  assign sram_rd_addr  = addr_q;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      RQ_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (out_size == '0) ? RQ_DONE : RQ_RUN;
        end
      end
      RQ_RUN: begin
        busy = 1'b1;
        if (credit_ok) begin
          rd_en = 1'b1;
          if (rd_last) state_d = RQ_DRAIN;
        end
      end
      RQ_DRAIN: begin
        busy = 1'b1;
        if (pop && head_last) state_d = RQ_DONE;
      end
      RQ_DONE: begin
        done    = 1'b1;
        state_d = RQ_IDLE;
      end
      default: state_d = RQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RQ_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      zp_q    <= '0;
      min_q   <= '0;
      max_q   <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q   <= out_size;
        addr_q  <= '0;
        mult_q  <= quant_mult;
        shift_q <= quant_shift;
        zp_q    <= out_zero_point;
        min_q   <= act_min;
        max_q   <= act_max;
        user_q  <= num_channels;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {core_last, core_data};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_requant_stream_out.sv
// Scoreboard bench for requant_stream_out with an arithmetic reference model and SRAM model.
module tb_requant_stream_out;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [12:0]       out_size = '0;
  logic signed [31:0] quant_mult = '0;
  logic [4:0]        quant_shift = '0;
  logic signed [7:0] out_zero_point = '0;
  logic signed [7:0] act_min = '0;
  logic signed [7:0] act_max = '0;
  logic [6:0]        num_channels = '0;
  logic              sram_rd_en;
  logic [12:0]       sram_rd_addr;
  logic signed [15:0] sram_rd_data = '0;
  logic signed [7:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [6:0]        m_axis_tuser;
  logic              busy;
  logic              done;

  requant_stream_out #(
    .ADDR_WIDTH (13), .ACC_WIDTH (16), .OUT_WIDTH (8),
    .NUM_CHANNELS_WIDTH (7), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .out_size (out_size),
    .quant_mult (quant_mult), .quant_shift (quant_shift),
    .out_zero_point (out_zero_point), .act_min (act_min), .act_max (act_max),
    .num_channels (num_channels), .sram_rd_en (sram_rd_en),
    .sram_rd_addr (sram_rd_addr), .sram_rd_data (sram_rd_data),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready), .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] d;
    logic              l;
    logic [6:0]        u;
  } exp_t;

  exp_t exp_q[$];
  logic signed [15:0] mem [64];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int reads_left = 0;
  int exp_addr = 0;
  int outstanding = 0;
  int beats = 0;
  int done_cnt = 0;
  int last_hs_cyc = -10;
  int zero_start_cyc = 0;
  bit zero_frame = 0;
  int tready_mode = 0;

  bit prev_stall = 0;
  logic signed [7:0] prev_d;
  logic prev_l;
  logic [6:0] prev_u;

  always @(posedge clk) cyc++;

  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr[5:0]];

  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Floor division formulation of round-half-up, then zero point and clamp.
  function automatic logic signed [7:0] model(int acc, longint mult, int sh, int zp, int mn, int mx);
    longint p, num, den, q, v;
    p   = longint'(acc) * mult;
    den = longint'(1) <<< (31 + sh);
    num = p + den / 2;
    q   = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    v = q + zp;
    if (v < mn) v = mn;
    if (v > mx) v = mx;
    return 8'(v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 0;
      outstanding = 0;
      reads_left  = 0;
    end else begin
      if (sram_rd_en) begin
        checks++;
        if (reads_left == 0 || sram_rd_addr != 13'(exp_addr)) begin
          errors++;
          $display("FAIL rd_addr: got addr=%0d reads_left=%0d, required addr=%0d with reads_left>0",
                   sram_rd_addr, reads_left, exp_addr);
        end
        if (reads_left > 0) reads_left--;
        exp_addr++;
        outstanding++;
        checks++;
        if (outstanding > 4) begin
          errors++;
          $display("FAIL credit: outstanding=%0d, required <=4", outstanding);
        end
      end
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata != prev_d || m_axis_tlast != prev_l || m_axis_tuser != prev_u) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b u=%0d, required v=1 d=%0d l=%0b u=%0d",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, prev_d, prev_l, prev_u);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat d=%0d l=%0b, required none", m_axis_tdata, m_axis_tlast);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata != e.d || m_axis_tlast != e.l || m_axis_tuser != e.u) begin
            errors++;
            $display("FAIL beat: got d=%0d l=%0b u=%0d, required d=%0d l=%0b u=%0d",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
          end
        end
        outstanding--;
        beats++;
        if (m_axis_tlast) last_hs_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      prev_u = m_axis_tuser;
      if (done) begin
        checks++;
        done_cnt++;
        if (zero_frame ? !(cyc - zero_start_cyc inside {[1:2]}) : (cyc != last_hs_cyc + 1)) begin
          errors++;
          $display("FAIL done_timing: done at cyc=%0d, last_hs=%0d zero_start=%0d", cyc, last_hs_cyc, zero_start_cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_frame(input int size, input longint mult, input int sh, input int zp,
                            input int mn, input int mx, input logic [6:0] user);
    exp_t e;
    for (int i = 0; i < size; i++) begin
      e.d = model(int'(mem[i]), mult, sh, zp, mn, mx);
      e.l = (i == size - 1);
      e.u = user;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input int size, input longint mult, input int sh, input int zp,
                             input int mn, input int mx, input logic [6:0] user);
    @(posedge clk); #1;
    out_size       = 13'(size);
    quant_mult     = 32'(mult);
    quant_shift    = 5'(sh);
    out_zero_point = 8'(zp);
    act_min        = 8'(mn);
    act_max        = 8'(mx);
    num_channels   = user;
    reads_left     = size;
    exp_addr       = 0;
    zero_frame     = (size == 0);
    zero_start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config mid-frame; the latched copy must be used
    out_size       = 13'($urandom_range(1, 63));
    quant_mult     = 32'($urandom_range(32'h7FFFFFFF, 1));
    quant_shift    = 5'($urandom);
    out_zero_point = 8'($urandom);
    num_channels   = 7'($urandom);
    if (size > 0) begin
      @(negedge clk);
      chk("busy_in_frame", longint'(busy), 1);
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
    chk("queue_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic directed(input int acc, input longint mult, input int sh, input int zp,
                          input int mn, input int mx, input logic signed [7:0] req);
    exp_t e;
    int d0;
    mem[0] = 16'(acc);
    e.d = req; e.l = 1'b1; e.u = 7'd3;
    exp_q.push_back(e);
    d0 = done_cnt;
    start_frame(1, mult, sh, zp, mn, mx, 7'd3);
    wait_done(d0);
  endtask

  initial begin
    int d0, n, b0, sz, sh, zp, a, b;
    longint mult;

    tready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", longint'(m_axis_tvalid), 0);
    chk("rst_tlast", longint'(m_axis_tlast), 0);
    chk("rst_tdata", longint'(m_axis_tdata), 0);
    chk("rst_tuser", longint'(m_axis_tuser), 0);
    chk("rst_rd_en", longint'(sram_rd_en), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    directed(100, 64'h40000000, 0, 0, -128, 127, 8'sd50);
    directed(100, 64'h40000000, 1, 0, -128, 127, 8'sd25);
    directed(-3, 64'h40000000, 0, 0, -128, 127, -8'sd1);
    directed(3, 64'h40000000, 0, 0, -128, 127, 8'sd2);
    directed(1000, 64'h7FFFFFFF, 0, 0, -128, 127, 8'sd127);
    directed(10, 64'h40000000, 0, -128, -128, 127, -8'sd123);
    directed(-50, 64'h40000000, 0, 0, 0, 127, 8'sd0);

    // 16-element frame: SRAM[i]=2i halves to i
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      mem[i] = 16'(2 * i);
      e.d = 8'(i); e.l = (i == 15); e.u = 7'd42;
      exp_q.push_back(e);
    end
    d0 = done_cnt;
    start_frame(16, 64'h40000000, 0, 0, -128, 127, 7'd42);
    wait_done(d0);

    // backpressure: hold tready low for 10 cycles after first tvalid
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    tready_mode = 2;
    @(posedge clk);
    push_frame(16, 64'h12345678, 2, 5, -100, 100, 7'd9);
    d0 = done_cnt;
    start_frame(16, 64'h12345678, 2, 5, -100, 100, 7'd9);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("bp_tvalid_seen", longint'(m_axis_tvalid), 1);
    repeat (10) @(posedge clk);
    tready_mode = 0;
    wait_done(d0);

    // empty frame
    d0 = done_cnt;
    start_frame(0, 64'h40000000, 0, 0, -128, 127, 7'd1);
    wait_done(d0);
    repeat (3) @(posedge clk);
    zero_frame = 0;

    // reset mid-frame after 5 beats
    for (int i = 0; i < 20; i++) mem[i] = 16'($urandom);
    push_frame(20, 64'h30000000, 1, -3, -128, 127, 7'd11);
    b0 = beats;
    start_frame(20, 64'h30000000, 1, -3, -128, 127, 7'd11);
    n = 0;
    while (beats < b0 + 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rst_beats_reached", longint'(beats - b0 >= 5), 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_flush_tvalid", longint'(m_axis_tvalid), 0);
    chk("rst_flush_busy", longint'(busy), 0);
    rst = 1'b0;
    exp_q.delete();
    push_frame(20, 64'h30000000, 1, -3, -128, 127, 7'd11);
    d0 = done_cnt;
    start_frame(20, 64'h30000000, 1, -3, -128, 127, 7'd11);
    wait_done(d0);

    // randomized frames with random backpressure
    tready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      sz   = int'($urandom_range(1, 40));
      mult = longint'($urandom_range(32'h7FFFFFFF, 1));
      sh   = int'($urandom_range(0, 8));
      zp   = int'($urandom_range(0, 255)) - 128;
      a    = int'($urandom_range(0, 255)) - 128;
      b    = int'($urandom_range(0, 255)) - 128;
      if (a > b) begin int t; t = a; a = b; b = t; end
      for (int i = 0; i < sz; i++) mem[i] = 16'($urandom);
      push_frame(sz, mult, sh, zp, a, b, 7'(f + 20));
      d0 = done_cnt;
      start_frame(sz, mult, sh, zp, a, b, 7'(f + 20));
      wait_done(d0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
